// File: rtl/spi_pkg.sv
// Shared types, widths and byte-packing helpers for the SPI frame scheduler.
package spi_pkg;

  localparam int FRAME_W = 14;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    GAP
  } sched_state_e;

  // The remote side rebuilds {upper, lower}[13:0], so the top two bits are padding.
  function automatic logic [BYTE_W-1:0] pack_hi(input logic [FRAME_W-1:0] data);
    return {2'b00, data[FRAME_W-1:BYTE_W]};
  endfunction

  function automatic logic [BYTE_W-1:0] pack_lo(input logic [FRAME_W-1:0] data);
    return data[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Frame request side and spi_master byte-engine side of the scheduler, bundled.
interface spi_frame_scheduler_if;
  import spi_pkg::*;

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic [BYTE_W-1:0]  spi_tx_data;
  logic               spi_start;
  logic               spi_ready;
  logic               spi_done;
  logic               ss;
  logic               busy;
  logic               frame_sent;
  logic               overrun;

  modport master (
    input  frame_data, frame_valid, spi_ready, spi_done,
    output spi_tx_data, spi_start, ss, busy, frame_sent, overrun
  );

  modport slave (
    output frame_data, frame_valid, spi_ready, spi_done,
    input  spi_tx_data, spi_start, ss, busy, frame_sent, overrun
  );

endinterface

// File: rtl/spi_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module spi_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/spi_frame_scheduler.sv
// Sends a 14-bit value as a two-byte SPI frame (upper then lower) with ss framing,
// a minimum inter-frame gap and a one-deep pending buffer.
module spi_frame_scheduler
  import spi_pkg::*;
#(
  parameter int SS_SETUP   = 4,
  parameter int GAP_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_frame_scheduler_if.master bus
);

  localparam int SETUP_EFF = (SS_SETUP < 1) ? 1 : SS_SETUP;
  localparam int GAP_EFF   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int MAX_EFF   = (SETUP_EFF > GAP_EFF) ? SETUP_EFF : GAP_EFF;
  localparam int TW        = $clog2(MAX_EFF + 1);
  // The timer is loaded on entry, so the state lasts load+1 cycles.
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_EFF - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_EFF - 1);

  sched_state_e       state_reg, state_next;
  logic [FRAME_W-1:0] cur_reg, cur_next;
  logic [FRAME_W-1:0] pend_data_reg, pend_data_next;
  logic               pend_valid_reg, pend_valid_next;
  logic [BYTE_W-1:0]  tx_reg, tx_next;
  logic               start_reg, start_next;
  logic               ss_reg, ss_next;
  logic               sent_reg, sent_next;
  logic               overrun_reg, overrun_next;
  logic               timer_load;
  logic [TW-1:0]      timer_value;
  logic               timer_expired;
  logic               consume;

  spi_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cur_reg        <= '0;
      pend_data_reg  <= '0;
      pend_valid_reg <= 1'b0;
      tx_reg         <= '0;
      start_reg      <= 1'b0;
      ss_reg         <= 1'b1;
      sent_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      pend_data_reg  <= pend_data_next;
      pend_valid_reg <= pend_valid_next;
      tx_reg         <= tx_next;
      start_reg      <= start_next;
      ss_reg         <= ss_next;
      sent_reg       <= sent_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    pend_data_next  = pend_data_reg;
    pend_valid_next = pend_valid_reg;
    tx_next         = tx_reg;
    start_next      = 1'b0;
    ss_next         = ss_reg;
    sent_next       = 1'b0;
    overrun_next    = 1'b0;
    timer_load      = 1'b0;
    timer_value     = '0;
    consume         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.frame_valid) begin
          cur_next    = bus.frame_data;
          ss_next     = 1'b0;
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        if (timer_expired) state_next = SEND_HI;
      end
      SEND_HI: begin
        if (bus.spi_ready) begin
          tx_next    = pack_hi(cur_reg);
          start_next = 1'b1;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.spi_done) state_next = SEND_LO;
      end
      SEND_LO: begin
        if (bus.spi_ready) begin
          tx_next    = pack_lo(cur_reg);
          start_next = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (bus.spi_done) begin
          ss_next     = 1'b1;
          sent_next   = 1'b1;
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
          state_next  = GAP;
        end
      end
      GAP: begin
        if (timer_expired) begin
          if (pend_valid_reg) begin
            consume     = 1'b1;
            cur_next    = pend_data_reg;
            ss_next     = 1'b0;
            timer_load  = 1'b1;
            timer_value = SETUP_LOAD;
            state_next  = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A strobe in the same cycle the pending slot drains simply refills it.
    if (consume) pend_valid_next = 1'b0;
    if (bus.frame_valid && (state_reg != IDLE)) begin
      pend_data_next  = bus.frame_data;
      pend_valid_next = 1'b1;
      overrun_next    = pend_valid_reg && !consume;
    end
  end

  assign bus.spi_tx_data = tx_reg;
  assign bus.spi_start   = start_reg;
  assign bus.ss          = ss_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.frame_sent  = sent_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench for spi_frame_scheduler with a behavioural spi_master byte engine.
module tb_spi_frame_scheduler;

  localparam int SS_SETUP   = 4;
  localparam int GAP_CYCLES = 10;
  localparam int BYTE_LAT   = 16;

  logic clk;
  logic reset;
  spi_frame_scheduler_if bus();

  spi_frame_scheduler #(.SS_SETUP(SS_SETUP), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_log[$];
  int start_cnt   = 0;
  int sent_cnt    = 0;
  int overrun_cnt = 0;
  int byte_timer  = 0;
  bit ready_hold  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // spi_master model: accepts a start when ready, pulses done BYTE_LAT cycles later.
  initial begin
    bus.spi_ready = 1'b1;
    bus.spi_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.spi_done = 1'b0;
      if (bus.spi_start === 1'b1) begin
        tx_log.push_back(bus.spi_tx_data);
        start_cnt++;
        byte_timer = BYTE_LAT;
      end else if (byte_timer > 0) begin
        byte_timer--;
        if (byte_timer == 0) bus.spi_done = 1'b1;
      end
      if (bus.frame_sent === 1'b1) sent_cnt++;
      if (bus.overrun === 1'b1) overrun_cnt++;
      bus.spi_ready = (byte_timer == 0) && !ready_hold;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [13:0] value);
    bus.frame_data  = value;
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_sent(input string tag, output int ss_bad);
    int n;
    n = 0;
    ss_bad = 0;
    while (bus.frame_sent !== 1'b1 && n < 500) begin
      if (bus.ss !== 1'b0) ss_bad++;
      step();
      n++;
    end
    check({tag, "_sent_timeout"}, (n < 500), 1);
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (bus.busy !== 1'b0 && cycles < 300) begin
      step();
      cycles++;
    end
    check({tag, "_idle_timeout"}, (cycles < 300), 1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    check({tag, "_count"}, tx_log.size(), 2);
    if (tx_log.size() >= 2) begin
      check({tag, "_byte0"}, tx_log[0], b0);
      check({tag, "_byte1"}, tx_log[1], b1);
    end
    tx_log.delete();
  endtask

  initial begin
    int lat;
    int ss_bad;
    int idle_cycles;
    int n;
    int bad;
    int sent_before;

    reset           = 1'b0;
    bus.frame_data  = '0;
    bus.frame_valid = 1'b0;
    repeat (3) step();

    check("rst_ss", bus.ss, 1);
    check("rst_start", bus.spi_start, 0);
    check("rst_tx", bus.spi_tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sent", bus.frame_sent, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b1;
    step();
    tx_log.delete();

    // Single frame 0x1A5C.
    send(14'h1A5C);
    check("f1_ss_fall", bus.ss, 0);
    check("f1_busy", bus.busy, 1);
    lat = 1;
    while (bus.spi_start !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    check("f1_start_latency", lat, SS_SETUP + 2);
    wait_sent("f1", ss_bad);
    check("f1_ss_low_during_frame", ss_bad, 0);
    check("f1_ss_high_at_sent", bus.ss, 1);
    wait_idle("f1", idle_cycles);
    check("f1_busy_clear_delay", idle_cycles, GAP_CYCLES);
    check("f1_sent_count", sent_cnt, 1);
    check("f1_start_count", start_cnt, 2);
    check_bytes("f1", 8'h1A, 8'h5C);

    // Max value.
    send(14'h3FFF);
    wait_sent("max", ss_bad);
    wait_idle("max", idle_cycles);
    check_bytes("max", 8'h3F, 8'hFF);

    // Back-to-back: second strobe lands while the first frame is in WAIT_HI.
    send(14'h0001);
    n = 0;
    while (bus.spi_start !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    step();
    send(14'h0002);
    wait_sent("b2b1", ss_bad);
    check_bytes("b2b1", 8'h00, 8'h01);
    n = 0;
    bad = 0;
    while (bus.ss !== 1'b0 && n < 100) begin
      if (bus.busy !== 1'b1) bad++;
      step();
      n++;
    end
    check("b2b_gap_ss_fall", n, GAP_CYCLES);
    check("b2b_busy_through_gap", bad, 0);
    wait_sent("b2b2", ss_bad);
    wait_idle("b2b", idle_cycles);
    check_bytes("b2b2", 8'h00, 8'h02);
    check("b2b_overrun", overrun_cnt, 0);

    // Overrun: 0x0020 is overwritten by 0x0030.
    send(14'h0010);
    n = 0;
    while (bus.spi_start !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    send(14'h0020);
    check("ovr_none_first", bus.overrun, 0);
    send(14'h0030);
    check("ovr_pulse", bus.overrun, 1);
    step();
    check("ovr_pulse_width", bus.overrun, 0);
    wait_sent("ovr1", ss_bad);
    check_bytes("ovr1", 8'h00, 8'h10);
    step();
    wait_sent("ovr2", ss_bad);
    wait_idle("ovr", idle_cycles);
    check_bytes("ovr2", 8'h00, 8'h30);
    check("ovr_count", overrun_cnt, 1);

    // spi_ready held low in SEND_HI.
    ready_hold = 1'b1;
    step();
    sent_before = start_cnt;
    send(14'h0040);
    bad = 0;
    for (int i = 0; i < 50 + SS_SETUP; i++) begin
      if (bus.spi_start !== 1'b0 || bus.ss !== 1'b0) bad++;
      step();
    end
    check("rdy_stall_clean", bad, 0);
    check("rdy_no_start", start_cnt, sent_before);
    ready_hold = 1'b0;
    n = 0;
    while (bus.spi_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    step();
    check("rdy_start_after_rise", bus.spi_start, 1);
    wait_sent("rdy", ss_bad);
    wait_idle("rdy", idle_cycles);
    check_bytes("rdy", 8'h00, 8'h40);

    // Reset in WAIT_LO with a value pending.
    sent_before = start_cnt + 2;
    send(14'h0050);
    n = 0;
    while (start_cnt < sent_before && n < 100) begin
      step();
      n++;
    end
    step();
    send(14'h0060);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rrst_ss", bus.ss, 1);
    check("rrst_busy", bus.busy, 0);
    sent_before = sent_cnt;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ss !== 1'b1 || bus.frame_sent !== 1'b0 || bus.busy !== 1'b0) bad++;
      step();
    end
    check("rrst_quiet", bad, 0);
    check("rrst_no_sent", sent_cnt, sent_before);
    tx_log.delete();
    send(14'h0123);
    wait_sent("post", ss_bad);
    check("post_ss_low", ss_bad, 0);
    wait_idle("post", idle_cycles);
    check_bytes("post", 8'h01, 8'h23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
